// File: rtl/wb_regfile_unit.sv
// wb_regfile_unit: write-back stage with integer register file.
// Handles commit of ALU results and formatted load data, load-response
// wait with timeout, post-branch slot squashing and combinational reads.
// Optional feature: define WB_BYPASS_EN to forward commit-cycle write data
// to read ports selecting the destination register.
module wb_regfile_unit #(
   parameter int unsigned NREGS        = 32,
   parameter int unsigned NRD          = 2,
   parameter int unsigned FLUSH_SLOTS  = 2,
   parameter int unsigned LOAD_TIMEOUT = 15,
   localparam int unsigned WIDTH_R     = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pipe_stall,
   input  logic                   wb_valid,
   input  logic                   wb_rd_we,
   input  logic [WIDTH_R-1:0]     wb_rd,
   input  logic [31:0]            wb_result,
   input  logic                   wb_is_load,
   input  logic [2:0]             wb_funct3,
   input  logic [1:0]             wb_addr_lo,
   input  logic                   wb_branch,
   input  logic                   dmem_rsp_valid,
   input  logic [31:0]            dmem_rsp_data,
   input  logic [NRD*WIDTH_R-1:0] rd_sel,
   output logic [NRD*32-1:0]      rd_data,
   output logic                   wb_stall,
   output logic                   retire,
   output logic                   load_err
);

   localparam logic [7:0] TO_LIM  = 8'(LOAD_TIMEOUT);
   localparam logic [1:0] SQ_LOAD = 2'(FLUSH_SLOTS);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sq_cnt_q, sq_cnt_d;
   logic [7:0]  to_cnt_q, to_cnt_d;
   logic        retire_q, retire_d;
   logic        load_err_q, load_err_d;
   logic [31:0] regs_q [NREGS];
   logic [31:0] regs_d [NREGS];

   logic        squashed;
   logic        load_pend;
   logic        timeout;
   logic        to_hit;
   logic        stall_int;
   logic        advance;
   logic        commit;
   logic [31:0] load_fmt;
   logic [31:0] wdata;

   // Extract and extend the addressed byte/halfword of a raw load word.
   function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                            input logic [1:0]  lo,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lo[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b010:  fmt_load = d;
         3'b100:  fmt_load = {24'd0, b};
         3'b101:  fmt_load = {16'd0, h};
         default: fmt_load = '0;
      endcase
   endfunction

   // Slot qualification, stall, advance and write-data selection.
   always_comb begin
      squashed  = (sq_cnt_q != 2'd0);
      load_pend = wb_valid && wb_is_load && !squashed;
      timeout   = (state_q == S_WAIT) && (to_cnt_q == TO_LIM);
      to_hit    = timeout && !dmem_rsp_valid;
      stall_int = load_pend && !dmem_rsp_valid && !timeout;
      wb_stall  = reset && stall_int;
      advance   = wb_valid && !stall_int && !pipe_stall;
      commit    = advance && !squashed && wb_rd_we && (wb_rd != '0);
      load_fmt  = fmt_load(wb_funct3, wb_addr_lo, dmem_rsp_data);
      if (!wb_is_load)
         wdata = wb_result;
      else if (to_hit)
         wdata = '0;
      else
         wdata = load_fmt;
   end

   // Load-wait FSM, timeout counter (keeps counting through pipe_stall), error flag.
   always_comb begin
      state_d    = state_q;
      to_cnt_d   = to_cnt_q;
      load_err_d = load_err_q;
      case (state_q)
         S_IDLE: begin
            if (!pipe_stall && load_pend && !dmem_rsp_valid) begin
               state_d  = S_WAIT;
               to_cnt_d = 8'd1;
            end
         end
         S_WAIT: begin
            if (to_cnt_q != TO_LIM)
               to_cnt_d = to_cnt_q + 8'd1;
            if (!pipe_stall) begin
               if (!load_pend || dmem_rsp_valid || timeout) begin
                  state_d  = S_IDLE;
                  to_cnt_d = '0;
               end
               if (load_pend && to_hit)
                  load_err_d = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            to_cnt_d = '0;
         end
      endcase
   end

   // Squash counter and retire pulse.
   always_comb begin
      sq_cnt_d = sq_cnt_q;
      if (advance) begin
         if (squashed)
            sq_cnt_d = sq_cnt_q - 2'd1;
         else if (wb_branch)
            sq_cnt_d = SQ_LOAD;
      end
      retire_d = commit;
   end

   // Register array next state; r0 is hardwired to zero.
   always_comb begin
      regs_d = regs_q;
      if (commit)
         regs_d[wb_rd] = wdata;
      regs_d[0] = '0;
   end

   // Combinational read ports, forced to zero for r0 and during reset.
   always_comb begin
      rd_data = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         rd_data[k*32 +: 32] = regs_q[rd_sel[k*WIDTH_R +: WIDTH_R]];
`ifdef WB_BYPASS_EN
         if (commit && (rd_sel[k*WIDTH_R +: WIDTH_R] == wb_rd))
            rd_data[k*32 +: 32] = wdata;
`endif
         if (!reset || (rd_sel[k*WIDTH_R +: WIDTH_R] == '0))
            rd_data[k*32 +: 32] = '0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sq_cnt_q   <= '0;
         to_cnt_q   <= '0;
         retire_q   <= 1'b0;
         load_err_q <= 1'b0;
         regs_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         sq_cnt_q   <= sq_cnt_d;
         to_cnt_q   <= to_cnt_d;
         retire_q   <= retire_d;
         load_err_q <= load_err_d;
         regs_q     <= regs_d;
      end
   end

   assign retire   = retire_q;
   assign load_err = load_err_q;

endmodule

// File: doc/wb_regfile_unit.md
WB_REGFILE_UNIT -- requirements
Module: wb_regfile_unit

Interface
REQ-001 SHALL have parameter NREGS, default 32, register count (16 for RV32E or 32); WIDTH_R = log2(NREGS).
REQ-002 SHALL have parameter NRD, default 2, number of combinational read ports (1..4).
REQ-003 SHALL have parameter FLUSH_SLOTS, default 2, number of WB slots squashed after a taken branch (0..3).
REQ-004 SHALL have parameter LOAD_TIMEOUT, default 15, maximum wait cycles for a load response (1..255).
REQ-005 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- pipe_stall  in  1  external stall; WB slot holds.
- wb_valid  in  1  instruction present in WB.
- wb_rd_we  in  1  instruction writes rd.
- wb_rd  in  WIDTH_R  destination register.
- wb_result  in  32  ALU result.
- wb_is_load  in  1  instruction is a load.
- wb_funct3  in  3  load type (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- wb_addr_lo  in  2  load byte address [1:0].
- wb_branch  in  1  WB instruction is a taken branch/jump.
- dmem_rsp_valid  in  1  load data valid this cycle.
- dmem_rsp_data  in  32  raw load word.
- rd_sel  in  NRD*WIDTH_R  packed read selects; port k uses slice k.
- rd_data  out  NRD*32  packed read data.
- wb_stall  out  1  WB cannot advance.
- retire  out  1  one-cycle pulse, registered, one cycle after each commit.
- load_err  out  1  sticky load-timeout flag.

Function
REQ-006 SHALL define advance = wb_valid && !wb_stall && !pipe_stall.
REQ-007 SHALL keep squash counter sq_cnt (2 bits); slot squashed when sq_cnt != 0.
REQ-008 SHALL load sq_cnt = FLUSH_SLOTS on advance of a non-squashed instruction with wb_branch=1; SHALL decrement sq_cnt on each advance while sq_cnt != 0; wb_branch in a squashed slot ignored.
REQ-009 SHALL implement FSM IDLE/WAIT: IDLE->WAIT when a non-squashed load is in WB and dmem_rsp_valid=0; WAIT->IDLE on dmem_rsp_valid=1 or timeout.
REQ-010 SHALL assert wb_stall combinationally when a non-squashed load is in WB, dmem_rsp_valid=0, and timeout not reached; squashed loads never stall.
REQ-011 SHALL count WAIT cycles in an 8-bit counter; on count == LOAD_TIMEOUT, deassert wb_stall, commit load data 0, set load_err, return to IDLE.
REQ-012 SHALL commit (write regs[wb_rd]) when advance && !squashed && wb_rd_we && wb_rd != 0; writes to r0 discarded.
REQ-013 SHALL write wb_result for non-loads and formatted dmem_rsp_data for loads, in the commit cycle.
REQ-014 SHALL format loads: LB/LBU select byte wb_addr_lo, sign/zero-extend; LH/LHU select halfword wb_addr_lo[1] (bit 0 ignored), sign/zero-extend; LW whole word, wb_addr_lo ignored; other funct3 yield 0.
REQ-015 SHALL return 0 on any read port with rd_sel slice == 0; otherwise regs value (or bypass per REQ-020).
REQ-016 SHALL pulse retire for exactly one cycle, one cycle after each commit; squashed or stalled slots do not retire.
REQ-017 SHALL hold all state unchanged while pipe_stall=1, except the timeout counter, which still counts in WAIT.

Reset
REQ-018 SHALL on reset low asynchronously clear regs[1..NREGS-1] to 0, sq_cnt to 0, FSM to IDLE, timeout counter to 0, retire to 0, load_err to 0; reset mid-load abandons the load with no write.
REQ-019 SHALL drive wb_stall=0 and rd_data=0 for all selects during reset.

Configuration
REQ-020 SHALL, with macro WB_BYPASS_EN defined, forward the commit-cycle write data to any read port whose select equals wb_rd (nonzero); without it, read ports return array contents only, and a write is visible the cycle after commit.

Verification
REQ-021 ALU write: wb_rd=5, wb_result=0xDEADBEEF, commit; next cycle rd_sel[0]=5 -> 0xDEADBEEF; same-cycle read -> 0xDEADBEEF with WB_BYPASS_EN, old value 0 without.
REQ-022 Load formats: dmem_rsp_data=0x80FF7F01; LB addr_lo=3 -> 0xFFFFFF80; LBU addr_lo=2 -> 0x000000FF; LH addr_lo=2 -> 0xFFFF80FF; LHU addr_lo=0 -> 0x00007F01.
REQ-023 Load wait: load to r7, dmem_rsp_valid low 3 cycles then high with 0x12345678 -> wb_stall high 3 cycles, r7=0x12345678, single retire pulse.
REQ-024 Squash: FLUSH_SLOTS=2, branch advances, then two ALU writes to r1/r2, then write to r3 -> r1, r2 unchanged, r3 written, one retire for the branch slot (if wb_rd_we) and one for r3.
REQ-025 Timeout: LOAD_TIMEOUT=4, load to r9, no response -> stall 4 cycles, r9=0, load_err=1 until reset.
REQ-026 Reset mid-load: assert reset while FSM in WAIT -> wb_stall=0, all registers 0, no retire, load_err=0.
